// File: rtl/hilo_muldiv_ctrl_if.sv
// Command, HI/LO and divider-handshake signals of the EX-stage multiply/divide controller.
// master is the pipeline/divider side, slave is the controller.
interface hilo_muldiv_ctrl_if;
  logic        cmd_valid;
  logic [2:0]  cmd;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        stall_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        div_start;
  logic        div_signed;
  logic        div_annul;
  logic [31:0] div_opa;
  logic [31:0] div_opb;
  logic [63:0] div_result;
  logic        div_ready;

  modport master (
    output cmd_valid, cmd, a, b, flush, div_result, div_ready,
    input  stall_o, hi_o, lo_o, div_start, div_signed, div_annul, div_opa, div_opb
  );

  modport slave (
    input  cmd_valid, cmd, a, b, flush, div_result, div_ready,
    output stall_o, hi_o, lo_o, div_start, div_signed, div_annul, div_opa, div_opb
  );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO register owner for the EX stage: fixed-latency multiplier, handshake to the
// external multi-cycle divider, MTHI/MTLO writes and pipeline stall generation.
module hilo_muldiv_ctrl #(
  parameter int unsigned MUL_LAT = 2
) (
  input logic              clk,
  input logic              rst,
  hilo_muldiv_ctrl_if.slave bus
);

  localparam int CW = $clog2(MUL_LAT + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV_WAIT, DONE} state_e;

  state_e          state_q, state_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [31:0]     opa_q, opa_d, opb_q, opb_d;
  logic            signed_q, signed_d;
  logic            start_q, start_d;
  logic            annul_q, annul_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [63:0]     ext_a, ext_b, product;

  // Sign- or zero-extend the latched operands; the low 64 bits of the product are exact either way.
  always_comb begin
    ext_a   = {{32{opa_q[31] & signed_q}}, opa_q};
    ext_b   = {{32{opb_q[31] & signed_q}}, opb_q};
    product = ext_a * ext_b;
  end

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    signed_d = signed_q;
    start_d  = start_q;
    annul_d  = 1'b0;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid && !bus.flush) begin
          case (bus.cmd)
            3'd0, 3'd1: begin
              opa_d    = bus.a;
              opb_d    = bus.b;
              signed_d = (bus.cmd == 3'd0);
              cnt_d    = CW'(MUL_LAT - 1);
              state_d  = MUL;
            end
            3'd2, 3'd3: begin
              if (bus.b != 32'd0) begin
                opa_d    = bus.a;
                opb_d    = bus.b;
                signed_d = (bus.cmd == 3'd2);
                start_d  = 1'b1;
                state_d  = DIV_WAIT;
              end else begin
                state_d = DONE;
              end
            end
            3'd4:    hi_d = bus.a;
            3'd5:    lo_d = bus.a;
            default: ;
          endcase
        end
      end
      MUL: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          {hi_d, lo_d} = product;
          state_d      = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DIV_WAIT: begin
        // A cancelled instruction must never write HI/LO, even if the result arrives now.
        if (bus.flush) begin
          start_d = 1'b0;
          annul_d = 1'b1;
          state_d = IDLE;
        end else if (bus.div_ready) begin
          {hi_d, lo_d} = bus.div_result;
          start_d      = 1'b0;
          state_d      = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      signed_q <= 1'b0;
      start_q  <= 1'b0;
      annul_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      signed_q <= signed_d;
      start_q  <= start_d;
      annul_q  <= annul_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.stall_o = !bus.flush &&
                       ((state_q == MUL) || (state_q == DIV_WAIT) ||
                        ((state_q == IDLE) && bus.cmd_valid && !bus.cmd[2]));
  assign bus.hi_o       = hi_q;
  assign bus.lo_o       = lo_q;
  assign bus.div_start  = start_q;
  assign bus.div_signed = signed_q;
  assign bus.div_annul  = annul_q;
  assign bus.div_opa    = opa_q;
  assign bus.div_opb    = opb_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench for hilo_muldiv_ctrl with a behavioural divider of configurable latency.
module tb_hilo_muldiv_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hilo_muldiv_ctrl_if bus ();

  hilo_muldiv_ctrl #(.MUL_LAT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  int          div_lat   = 34;
  int          div_cnt   = 0;
  int          start_cnt = 0;
  int          annul_cnt = 0;

  // Divider model: result pulse on the div_lat-th cycle that div_start is held.
  always @(negedge clk) begin
    int sa, sb;
    if (bus.div_start === 1'b1) begin
      div_cnt++;
      start_cnt++;
      if (div_cnt == div_lat && bus.div_opb != 32'd0) begin
        sa = bus.div_opa;
        sb = bus.div_opb;
        if (bus.div_signed) bus.div_result = {32'(sa % sb), 32'(sa / sb)};
        else                bus.div_result = {bus.div_opa % bus.div_opb, bus.div_opa / bus.div_opb};
        bus.div_ready = 1'b1;
      end else begin
        bus.div_ready = 1'b0;
      end
    end else begin
      div_cnt       = 0;
      bus.div_ready = 1'b0;
    end
    if (bus.div_annul === 1'b1) annul_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one MULT/MULTU/DIV/DIVU to completion; expected HI/LO is queued at issue time.
  task automatic applyStimulus(input logic [2:0] c, input logic [31:0] op_a, input logic [31:0] op_b,
                               input int exp_stall, input string tag);
    logic [63:0] expv;
    int          stalls;
    int          q, r;
    expv = {m_hi, m_lo};
    if (c == 3'd0) expv = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
    else if (c == 3'd1) expv = {32'd0, op_a} * {32'd0, op_b};
    else if (op_b != 32'd0) begin
      if (c == 3'd2) begin
        q = $signed(op_a) / $signed(op_b);
        r = $signed(op_a) % $signed(op_b);
        expv = {32'(r), 32'(q)};
      end else begin
        expv = {op_a % op_b, op_a / op_b};
      end
    end
    {m_hi, m_lo} = expv;
    exp_q.push_back(expv);
    start_cnt     = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd       = c;
    bus.a         = op_a;
    bus.b         = op_b;
    bus.flush     = 1'b0;
    #1;
    checkOutput({tag, "_stall_accept"}, 64'(bus.stall_o), 64'd1);
    step();
    bus.a = $urandom;
    bus.b = $urandom;
    if (c[1] && op_b != 32'd0) checkOutput({tag, "_div_signed"}, 64'(bus.div_signed), 64'(c == 3'd2));
    stalls = 0;
    while (bus.stall_o && stalls < 200) begin
      stalls++;
      step();
    end
    checkOutput({tag, "_stall_cycles"}, 64'(stalls), 64'(exp_stall));
    checkOutput({tag, "_hilo"}, {bus.hi_o, bus.lo_o}, exp_q.pop_front());
    checkOutput({tag, "_start_cycles"}, 64'(start_cnt), 64'((c[1] && op_b != 32'd0) ? div_lat : 0));
    step();
    bus.cmd_valid = 1'b0;
    #1;
    checkOutput({tag, "_idle_stall"}, 64'(bus.stall_o), 64'd0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd       = 3'd7;
    bus.a         = $urandom;
    bus.b         = $urandom;
    bus.flush     = 1'b0;
    step();
    checkOutput("reset_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    checkOutput("reset_stall", 64'(bus.stall_o), 64'd0);
    checkOutput("reset_start", 64'(bus.div_start), 64'd0);
    rst           = 1'b0;
    bus.cmd_valid = 1'b0;
    step();

    applyStimulus(3'd0, 32'hFFFF_FFFD, 32'd5, 2, "mult_neg");
    applyStimulus(3'd1, 32'hFFFF_FFFF, 32'd2, 2, "multu_max");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(3'(i % 2), $urandom, $urandom, 2, "mul_rand");
    end
    applyStimulus(3'd2, 32'hFFFF_FFF9, 32'd2, 34, "div_neg");
    applyStimulus(3'd3, 32'd7, 32'd2, 34, "divu");
    applyStimulus(3'd2, 32'h1234_5678, 32'd0, 0, "div_zero");

    // MTHI then MTLO on consecutive cycles.
    bus.cmd_valid = 1'b1;
    bus.cmd       = 3'd4;
    bus.a         = 32'h1234_5678;
    m_hi          = 32'h1234_5678;
    exp_q.push_back({m_hi, m_lo});
    #1;
    checkOutput("mthi_stall", 64'(bus.stall_o), 64'd0);
    step();
    bus.cmd = 3'd5;
    bus.a   = 32'h9ABC_DEF0;
    #1;
    checkOutput("mtlo_stall", 64'(bus.stall_o), 64'd0);
    checkOutput("mthi_hilo", {bus.hi_o, bus.lo_o}, exp_q.pop_front());
    m_lo = 32'h9ABC_DEF0;
    exp_q.push_back({m_hi, m_lo});
    step();
    bus.cmd_valid = 1'b0;
    checkOutput("mtlo_hilo", {bus.hi_o, bus.lo_o}, exp_q.pop_front());

    // Flushed MTHI and undefined commands leave HI/LO alone.
    bus.cmd_valid = 1'b1;
    bus.cmd       = 3'd4;
    bus.a         = 32'hDEAD_BEEF;
    bus.flush     = 1'b1;
    exp_q.push_back({m_hi, m_lo});
    step();
    bus.flush = 1'b0;
    bus.cmd   = 3'd6;
    #1;
    checkOutput("cmd6_stall", 64'(bus.stall_o), 64'd0);
    step();
    bus.cmd_valid = 1'b0;
    checkOutput("flush_mthi_hilo", {bus.hi_o, bus.lo_o}, exp_q.pop_front());

    // Flush in the 10th divider wait cycle.
    annul_cnt     = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd       = 3'd2;
    bus.a         = 32'd100;
    bus.b         = 32'd7;
    exp_q.push_back({m_hi, m_lo});
    step();
    for (int i = 0; i < 9; i++) step();
    bus.flush = 1'b1;
    #1;
    checkOutput("flush_div_stall", 64'(bus.stall_o), 64'd0);
    step();
    bus.flush     = 1'b0;
    bus.cmd_valid = 1'b0;
    checkOutput("flush_div_start", 64'(bus.div_start), 64'd0);
    step();
    step();
    checkOutput("flush_div_annul", 64'(annul_cnt), 64'd1);
    checkOutput("flush_div_hilo", {bus.hi_o, bus.lo_o}, exp_q.pop_front());

    // Flush arriving in the same cycle as div_ready.
    div_lat       = 5;
    bus.cmd_valid = 1'b1;
    bus.cmd       = 3'd3;
    bus.a         = 32'd50;
    bus.b         = 32'd3;
    exp_q.push_back({m_hi, m_lo});
    step();
    for (int i = 0; i < 4; i++) step();
    bus.flush = 1'b1;
    step();
    bus.flush     = 1'b0;
    bus.cmd_valid = 1'b0;
    step();
    checkOutput("flush_ready_hilo", {bus.hi_o, bus.lo_o}, exp_q.pop_front());
    checkOutput("flush_ready_stall", 64'(bus.stall_o), 64'd0);
    div_lat = 34;
    applyStimulus(3'd3, 32'd1000, 32'd9, 34, "divu_after_flush");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
